// File: rtl/pe_array_controller_if.sv
// Control bundle between the job sequencer / PE array and the PE controller.
// Optional stall_cycles signal exists only when PE_CTRL_STALL_CNT_EN is defined.
interface pe_array_controller_if #(
  parameter int WIN_W = 8
);
  logic             start;
  logic [WIN_W-1:0] num_windows;
  logic             filter_avail;
  logic             ifmap_avail;
  logic             read_new_filter_val;
  logic             read_new_ifmap_val;
  logic             start_conv;
  logic             busy;
  logic             done;
  logic [WIN_W-1:0] window_idx;
`ifdef PE_CTRL_STALL_CNT_EN
  logic [15:0]      stall_cycles;
`endif

  modport master (
    input  start,
    input  num_windows,
    input  filter_avail,
    input  ifmap_avail,
    output read_new_filter_val,
    output read_new_ifmap_val,
    output start_conv,
    output busy,
    output done,
`ifdef PE_CTRL_STALL_CNT_EN
    output stall_cycles,
`endif
    output window_idx
  );

  modport slave (
    output start,
    output num_windows,
    output filter_avail,
    output ifmap_avail,
    input  read_new_filter_val,
    input  read_new_ifmap_val,
    input  start_conv,
    input  busy,
    input  done,
`ifdef PE_CTRL_STALL_CNT_EN
    input  stall_cycles,
`endif
    input  window_idx
  );
endinterface

// File: rtl/pe_array_controller.sv
// PE array controller: filter load, ifmap window loads and conv bursts per job.
// Define PE_CTRL_STALL_CNT_EN to add the saturating stall_cycles counter.
module pe_array_controller #(
  parameter int FILTER_LEN  = 3,
  parameter int IFMAP_LEN   = 3,
  parameter int SLIDE_LEN   = 1,
  parameter int CONV_CYCLES = 3,
  parameter int WIN_W       = 8
) (
  input  logic clk,
  input  logic rst,
  pe_array_controller_if.master ctrl_io
);

  localparam int L1 = (FILTER_LEN > IFMAP_LEN) ? FILTER_LEN : IFMAP_LEN;
  localparam int L2 = (L1 > SLIDE_LEN) ? L1 : SLIDE_LEN;
  localparam int L3 = (L2 > CONV_CYCLES) ? L2 : CONV_CYCLES;
  localparam int CW = $clog2(L3 + 1);

  localparam logic [CW-1:0] FILT_LAST = CW'(FILTER_LEN - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] IFMAP_L   = CW'(IFMAP_LEN);
  localparam logic [CW-1:0] SLIDE_L   = CW'(SLIDE_LEN);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_FILT,
    LOAD_IFMAP,
    CONV,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    load_len_q, load_len_d;
  logic [WIN_W-1:0] nwin_q, nwin_d;
  logic [WIN_W-1:0] widx_q, widx_d;

`ifdef PE_CTRL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      load_len_q <= IFMAP_L;
      nwin_q     <= WIN_ONE;
      widx_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_len_q <= load_len_d;
      nwin_q     <= nwin_d;
      widx_q     <= widx_d;
    end
  end

`ifdef PE_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign ctrl_io.stall_cycles = stall_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_len_d = load_len_q;
    nwin_d     = nwin_q;
    widx_d     = widx_q;
`ifdef PE_CTRL_STALL_CNT_EN
    stall_d    = stall_q;
`endif
    ctrl_io.read_new_filter_val = 1'b0;
    ctrl_io.read_new_ifmap_val  = 1'b0;
    ctrl_io.start_conv          = 1'b0;
    ctrl_io.done                = 1'b0;
    ctrl_io.busy                = (state_q != IDLE);

    unique case (1'b1)
      (state_q == IDLE): begin
        if (ctrl_io.start) begin
          nwin_d  = (ctrl_io.num_windows == '0) ? WIN_ONE
                                                : ctrl_io.num_windows;
          widx_d  = '0;
          cnt_d   = '0;
          state_d = LOAD_FILT;
`ifdef PE_CTRL_STALL_CNT_EN
          stall_d = '0;
`endif
        end
      end
      (state_q == LOAD_FILT): begin
        ctrl_io.read_new_filter_val = ctrl_io.filter_avail;
        if (ctrl_io.filter_avail) begin
          if (cnt_q == FILT_LAST) begin
            cnt_d      = '0;
            load_len_d = IFMAP_L;
            state_d    = LOAD_IFMAP;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
`ifdef PE_CTRL_STALL_CNT_EN
        else if (stall_q != 16'hFFFF) begin
          stall_d = stall_q + 16'd1;
        end
`endif
      end
      (state_q == LOAD_IFMAP): begin
        ctrl_io.read_new_ifmap_val = ctrl_io.ifmap_avail;
        if (ctrl_io.ifmap_avail) begin
          if (cnt_q == load_len_q - CNT_ONE) begin
            cnt_d   = '0;
            state_d = CONV;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
`ifdef PE_CTRL_STALL_CNT_EN
        else if (stall_q != 16'hFFFF) begin
          stall_d = stall_q + 16'd1;
        end
`endif
      end
      (state_q == CONV): begin
        ctrl_io.start_conv = 1'b1;
        if (cnt_q == CONV_LAST) begin
          cnt_d = '0;
          if (widx_q == nwin_q - WIN_ONE) begin
            state_d = DONE;
          end else begin
            widx_d     = widx_q + WIN_ONE;
            load_len_d = SLIDE_L;
            state_d    = LOAD_IFMAP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      (state_q == DONE): begin
        ctrl_io.done = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ctrl_io.window_idx = widx_q;

endmodule

// File: tb/tb_pe_array_controller.sv
// Scoreboard bench: each accepted job expands into an ordered list of PE ops
// that the monitor consumes cycle by cycle, gated by the avail inputs.
module tb_pe_array_controller;

  localparam int FL    = 3;
  localparam int IL    = 3;
  localparam int SL    = 1;
  localparam int CC    = 3;
  localparam int WIN_W = 8;

  localparam int OP_F = 0;
  localparam int OP_I = 1;
  localparam int OP_C = 2;
  localparam int OP_D = 3;

  typedef struct {
    int op;
    int widx;
  } ev_t;

  logic clk = 1'b0;
  logic rst;

  pe_array_controller_if #(.WIN_W(WIN_W)) bus ();

  pe_array_controller #(
    .FILTER_LEN (FL),
    .IFMAP_LEN  (IL),
    .SLIDE_LEN  (SL),
    .CONV_CYCLES(CC),
    .WIN_W      (WIN_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ctrl_io(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ev_t         q[$];
  logic [15:0] stall_m = '0;
  int          last_w  = 0;
  int          job_cyc = 0;
  int          job_st  = 0;
  int          job_n   = 1;
  int          jobs_done = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic push_job(input int n);
    for (int k = 0; k < FL; k++) q.push_back('{OP_F, 0});
    for (int k = 0; k < IL; k++) q.push_back('{OP_I, 0});
    for (int k = 0; k < CC; k++) q.push_back('{OP_C, 0});
    for (int w = 1; w < n; w++) begin
      for (int k = 0; k < SL; k++) q.push_back('{OP_I, w});
      for (int k = 0; k < CC; k++) q.push_back('{OP_C, w});
    end
    q.push_back('{OP_D, n - 1});
  endtask

  // Reference: the head of the op list says what the PE array must see now.
  always @(negedge clk) begin
    logic ef, ei, ec, ed, eb, stall;
    int   ew;
    ev_t  h;
    if (rst) begin
      q.delete();
      stall_m = '0;
      last_w  = 0;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
    end else begin
      ef = 1'b0; ei = 1'b0; ec = 1'b0; ed = 1'b0;
      ew = last_w;
      eb = (q.size() != 0);
      h  = '{OP_D, 0};
      if (eb) begin
        h  = q[0];
        ew = h.widx;
        case (h.op)
          OP_F: ef = bus.filter_avail;
          OP_I: ei = bus.ifmap_avail;
          OP_C: ec = 1'b1;
          default: ed = 1'b1;
        endcase
      end
      chk("filter_val", 32'(bus.read_new_filter_val), 32'(ef));
      chk("ifmap_val",  32'(bus.read_new_ifmap_val),  32'(ei));
      chk("start_conv", 32'(bus.start_conv),          32'(ec));
      chk("done",       32'(bus.done),                32'(ed));
      chk("busy",       32'(bus.busy),                32'(eb));
      chk("window_idx", 32'(bus.window_idx),          32'(ew));
`ifdef PE_CTRL_STALL_CNT_EN
      chk("stall_cycles", 32'(bus.stall_cycles), 32'(stall_m));
`endif
      if (eb) begin
        job_cyc++;
        stall = (h.op == OP_F && !bus.filter_avail) ||
                (h.op == OP_I && !bus.ifmap_avail);
        if (stall) begin
          job_st++;
          if (stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
        end else begin
          void'(q.pop_front());
          if (h.op == OP_D) begin
            last_w = h.widx;
            jobs_done++;
            chk("job_len", 32'(job_cyc),
                32'(FL + IL + CC + (job_n - 1) * (SL + CC) + 1 + job_st));
          end
        end
      end else if (bus.start) begin
        job_n   = (bus.num_windows == '0) ? 1 : int'(bus.num_windows);
        stall_m = '0;
        job_cyc = 0;
        job_st  = 0;
        push_job(job_n);
      end
    end
  end

  task automatic drive(input logic s, input int nw, input logic fa,
                       input logic ia);
    bus.start        = s;
    bus.num_windows  = WIN_W'(nw);
    bus.filter_avail = fa;
    bus.ifmap_avail  = ia;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input bit rnd);
    int k;
    k = 0;
    while (bus.busy && k < 500) begin
      if (rnd)
        drive(($urandom % 4) == 0, $urandom_range(0, 255),
              ($urandom % 10) < 7, ($urandom % 10) < 7);
      else
        drive(1'b0, 0, 1'b1, 1'b1);
      k++;
    end
    chk("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int dones_before;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.num_windows  = '0;
    bus.filter_avail = 1'b1;
    bus.ifmap_avail  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_widx", 32'(bus.window_idx), 32'd0);
    rst = 1'b0;
    drive(1'b0, 0, 1'b1, 1'b1);

    // two windows, no stalls
    drive(1'b1, 2, 1'b1, 1'b1);
    wait_idle(1'b0);
    drive(1'b0, 0, 1'b1, 1'b1);

    // zero windows behaves as one
    drive(1'b1, 0, 1'b1, 1'b1);
    wait_idle(1'b0);
    drive(1'b0, 0, 1'b1, 1'b1);

    // filter stall in cycles 2-3
    drive(1'b1, 1, 1'b1, 1'b1);
    drive(1'b0, 1, 1'b1, 1'b1);
    drive(1'b0, 1, 1'b0, 1'b1);
    drive(1'b0, 1, 1'b0, 1'b1);
    wait_idle(1'b0);
`ifdef PE_CTRL_STALL_CNT_EN
    chk("stall_two", 32'(bus.stall_cycles), 32'd2);
`endif
    drive(1'b0, 0, 1'b1, 1'b1);

    // start during CONV of window 0 is ignored
    dones_before = jobs_done;
    drive(1'b1, 2, 1'b1, 1'b1);
    repeat (7) drive(1'b0, 2, 1'b1, 1'b1);
    drive(1'b1, 5, 1'b1, 1'b1);
    wait_idle(1'b0);
    repeat (3) drive(1'b0, 0, 1'b1, 1'b1);
    chk("single_done", 32'(jobs_done - dones_before), 32'd1);

    // async reset mid LOAD_IFMAP
    drive(1'b1, 1, 1'b1, 1'b1);
    repeat (4) drive(1'b0, 1, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy",   32'(bus.busy),                32'd0);
    chk("arst_ifmap",  32'(bus.read_new_ifmap_val),  32'd0);
    chk("arst_filter", 32'(bus.read_new_filter_val), 32'd0);
    chk("arst_conv",   32'(bus.start_conv),          32'd0);
    chk("arst_done",   32'(bus.done),                32'd0);
    chk("arst_widx",   32'(bus.window_idx),          32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 1, 1'b1, 1'b1);
    wait_idle(1'b0);
    drive(1'b0, 0, 1'b1, 1'b1);

    // start held high: back-to-back jobs
    repeat (30) drive(1'b1, 1, 1'b1, 1'b1);
    wait_idle(1'b0);
    drive(1'b0, 0, 1'b1, 1'b1);

    // randomized jobs with random stalls and stray starts
    for (int j = 0; j < 25; j++) begin
      drive(1'b1, $urandom_range(0, 4), ($urandom % 10) < 7,
            ($urandom % 10) < 7);
      wait_idle(1'b1);
      if ($urandom % 2) drive(1'b0, 0, 1'b1, 1'b1);
    end

    repeat (3) drive(1'b0, 0, 1'b1, 1'b1);
    wait_idle(1'b0);
    repeat (2) drive(1'b0, 0, 1'b1, 1'b1);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
